// File: rtl/pos_match_irq.sv
// Position-compare interrupt stage feeding an external AND8 macro.
// An 8-bit position counter is compared bitwise against a CPU-written compare
// register. The registered equality terms drive AND8 inputs A..H, and the
// AND8 output comes back as allmatch. Its rising edge raises an interrupt
// request with acknowledge handshake and a sticky overrun flag.
module pos_match_irq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetl,
  input  logic             tick,
  input  logic             cnt_clr,
  input  logic             cmp_wr,
  input  logic [WIDTH-1:0] cmp_din,
  input  logic             irq_en,
  input  logic             ack,
  input  logic             allmatch,
  output logic [WIDTH-1:0] eq,
  output logic [WIDTH-1:0] pos,
  output logic             irq,
  output logic             missed
);

  // The fan-in of the AND8 macro fixes the compare width.
  if (WIDTH != 8) begin : g_bad_width
    $error("pos_match_irq: WIDTH must be 8 to match the AND8 fan-in");
  end

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic [WIDTH-1:0] eq_q,  eq_d;
  logic             match_q;
  logic             rise;
  state_e           state_q, state_d;
  logic             irq_q;
  logic             missed_q, missed_d;

  // Counter, compare register and equality-term next-state.
  always_comb begin
    pos_d = pos_q;
    if (cnt_clr) begin
      pos_d = '0;
    end else if (tick) begin
      pos_d = pos_q + WIDTH'(1);
    end
    cmp_d = cmp_wr ? cmp_din : cmp_q;
    eq_d  = ~(pos_q ^ cmp_q);
  end

  // Datapath registers: position, compare value, equality terms, match history.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      pos_q   <= '0;
      cmp_q   <= '1;
      eq_q    <= '0;
      match_q <= 1'b0;
    end else begin
      pos_q   <= pos_d;
      cmp_q   <= cmp_d;
      eq_q    <= eq_d;
      match_q <= allmatch;
    end
  end

  assign rise = allmatch & ~match_q;

  // Request/acknowledge FSM next-state and overrun flag next-state.
  always_comb begin
    state_d  = state_q;
    missed_d = missed_q;
    if (ack) begin
      missed_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (rise && irq_en) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (!irq_en) begin
          state_d = IDLE;
        end else if (ack) begin
          state_d = rise ? PEND : IDLE;
        end else if (rise) begin
          missed_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state with irq registered alongside it from the next state.
  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      irq_q    <= (state_d == PEND);
      missed_q <= missed_d;
    end
  end

  assign eq     = eq_q;
  assign pos    = pos_q;
  assign irq    = irq_q;
  assign missed = missed_q;

endmodule

// File: tb/tb_pos_match_irq.sv
// Directed bench for pos_match_irq; the AND8 macro is modelled as &eq.
module tb_pos_match_irq;

  logic       clk;
  logic       resetl;
  logic       tick;
  logic       cnt_clr;
  logic       cmp_wr;
  logic [7:0] cmp_din;
  logic       irq_en;
  logic       ack;
  logic       allmatch;
  logic [7:0] eq;
  logic [7:0] pos;
  logic       irq;
  logic       missed;

  int total;
  int bad;

  pos_match_irq #(.WIDTH(8)) dut (
    .clk      (clk),
    .resetl   (resetl),
    .tick     (tick),
    .cnt_clr  (cnt_clr),
    .cmp_wr   (cmp_wr),
    .cmp_din  (cmp_din),
    .irq_en   (irq_en),
    .ack      (ack),
    .allmatch (allmatch),
    .eq       (eq),
    .pos      (pos),
    .irq      (irq),
    .missed   (missed)
  );

  assign allmatch = &eq;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int irq_cnt;
    logic wrap_seen;
    logic [7:0] prev_pos;

    total   = 0;
    bad     = 0;
    resetl  = 1'b0;
    tick    = 1'b0;
    cnt_clr = 1'b0;
    cmp_wr  = 1'b0;
    cmp_din = 8'h00;
    irq_en  = 1'b0;
    ack     = 1'b0;
    #12;
    check("rst_pos", pos, 8'h00);
    check("rst_eq", eq, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_missed", missed, 1'b0);
    resetl = 1'b1;
    #10;

    // cmp=3, enable, three ticks
    cmp_wr = 1'b1; cmp_din = 8'h03; irq_en = 1'b1;
    step();
    cmp_wr = 1'b0;
    tick = 1'b1;
    step(); step(); step();
    tick = 1'b0;
    check("tick3_pos", pos, 8'h03);
    check("tick3_eq", eq, 8'hFE);
    check("tick3_irq", irq, 1'b0);
    step();
    check("eq_lag", eq, 8'hFF);
    check("eq_lag_irq", irq, 1'b0);
    step();
    check("irq_rise", irq, 1'b1);
    step(); step(); step();
    check("irq_hold", irq, 1'b1);
    check("irq_hold_missed", missed, 1'b0);

    // ack clears, no re-trigger while matched
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_clear", irq, 1'b0);
    step(); step(); step();
    check("no_retrig", irq, 1'b0);
    check("no_retrig_eq", eq, 8'hFF);

    // cmp=FF, 256 free-running ticks with automatic ack
    cmp_wr = 1'b1; cmp_din = 8'hFF;
    step();
    cmp_wr = 1'b0;
    step(); step();
    irq_cnt = 0;
    wrap_seen = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 256; i++) begin
      prev_pos = pos;
      step();
      if (prev_pos == 8'hFF && pos == 8'h00) wrap_seen = 1'b1;
      if (irq) irq_cnt++;
      ack = irq;
    end
    tick = 1'b0;
    step();
    if (irq) irq_cnt++;
    ack = 1'b0;
    step(); step();
    if (irq) irq_cnt++;
    check("wrap_pos", pos, 8'h03);
    check("wrap_seen", wrap_seen, 1'b1);
    check("one_irq_per_pass", irq_cnt, 1);
    check("wrap_missed", missed, 1'b0);
    tick = 1'b1; cnt_clr = 1'b1;
    step();
    tick = 1'b0; cnt_clr = 1'b0;
    check("clr_beats_tick", pos, 8'h00);

    // cmp=1: overrun, then ack coinciding with a rise
    cmp_wr = 1'b1; cmp_din = 8'h01;
    step();
    cmp_wr = 1'b0;
    step(); step();
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    check("p1_irq", irq, 1'b1);
    check("p1_missed", missed, 1'b0);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    check("ovr_missed", missed, 1'b1);
    check("ovr_irq", irq, 1'b1);
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    step();
    ack = 1'b1; step(); ack = 1'b0;
    check("ackrise_irq", irq, 1'b1);
    check("ackrise_missed", missed, 1'b0);
    ack = 1'b1; step(); ack = 1'b0;
    check("ack_idle", irq, 1'b0);

    // rise with irq_en low is ignored, not retroactive
    irq_en = 1'b0;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    step(); step(); step();
    check("dis_irq", irq, 1'b0);
    check("dis_eq", eq, 8'hFF);
    irq_en = 1'b1;
    step(); step();
    check("en_late_irq", irq, 1'b0);

    // irq_en dropped while pending
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    check("p2_irq", irq, 1'b1);
    irq_en = 1'b0; step();
    check("en_drop", irq, 1'b0);

    // asynchronous reset mid-PEND with missed set
    irq_en = 1'b1;
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    check("pre_rst_irq", irq, 1'b1);
    check("pre_rst_missed", missed, 1'b1);
    #2;
    resetl = 1'b0;
    #1;
    check("arst_irq", irq, 1'b0);
    check("arst_missed", missed, 1'b0);
    check("arst_eq", eq, 8'h00);
    check("arst_pos", pos, 8'h00);
    check("arst_cmp", dut.cmp_q, 8'hFF);
    #10;
    resetl = 1'b1;
    step();
    check("post_rst_irq", irq, 1'b0);
    check("post_rst_eq", eq, 8'h00);
    step();
    check("post_rst_irq2", irq, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pos_match_irq.md
Name: pos_match_irq

Overview:
- Position-compare interrupt stage built around the 8-input AND macro.
- Keeps an 8-bit position counter and a CPU-written compare register, and drives eight registered per-bit equality terms into the AND8 inputs A..H.
- Consumes the AND8 output Q as `allmatch`, edge-detects it, and runs an interrupt request/acknowledge handshake with overrun flagging.
- Sits between the video/timer position logic and the interrupt controller.

Parameters:
- WIDTH, 8, compare width. Only 8 is legal because it matches the AND8 fan-in; any other value is an elaboration error.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- resetl  input  1  asynchronous, active-low reset.
- tick  input  1  position advance strobe.
- cnt_clr  input  1  synchronous counter clear (e.g. frame start).
- cmp_wr  input  1  compare register write strobe.
- cmp_din  input  8  compare value.
- irq_en  input  1  interrupt enable.
- ack  input  1  interrupt acknowledge from the CPU side.
- allmatch  input  1  AND8 Q, driven combinationally from eq.
- eq  output  8  registered per-bit equality terms, to AND8 A..H (bit0 = A).
- pos  output  8  current position counter.
- irq  output  1  interrupt request, registered.
- missed  output  1  sticky overrun flag.

Behaviour:
- Reset (resetl low, asynchronous, effective immediately, also mid-handshake): pos=0x00, cmp=0xFF, eq=0x00, match_d=0, state=IDLE, irq=0, missed=0. On release, the first active edge is the first clk rise with resetl high.
- Counter:
  - cnt_clr → pos=0.
  - else tick → pos=pos+1, wrapping modulo 256 (0xFF→0x00).
  - else hold.
  - cnt_clr beats tick in the same cycle.
- Compare register: cmp_wr loads cmp_din at the edge. It has no interaction with the counter.
- Equality: at every edge, eq <= ~(pos ^ cmp), using the pre-edge pos and cmp. eq therefore lags pos/cmp by one cycle. allmatch is high only when eq=0xFF; the block does not AND internally.
- Edge detect:
  - match_d <= allmatch every edge.
  - rise = allmatch & ~match_d.
  - A position that stays matched with no tick produces exactly one rise.
- FSM, two states; irq = (state==PEND), registered:
  - IDLE: rise & irq_en → PEND. Otherwise stay.
  - PEND, irq_en low → IDLE. missed is unchanged.
  - PEND, ack & rise → stay PEND (new request). missed is not set.
  - PEND, ack & ~rise → IDLE.
  - PEND, rise & ~ack → stay PEND, set missed.
- missed:
  - Sticky.
  - Cleared by ack.
  - If a set and an ack-clear occur on the same edge, set wins. This case can only arise via the IDLE path being impossible, so it is effectively ack-clear.
- rise while irq_en low: ignored entirely and not recorded. A later irq_en rise does not create a retroactive request.
- Latency, counting the edge that samples the strobe as edge 1:
  - tick: pos updates at edge 1, eq at edge 2, irq high after edge 3.
  - cmp_wr of a value equal to the current pos: irq high after edge 3 (cmp edge 1, eq edge 2, PEND edge 3).
  - ack: irq low after edge 1.
- cmp written while pos is already matched with a different value: allmatch falls at the next eq update, and no request is generated.

Test Plan:
- Reset, then cmp_wr=1/cmp_din=0x03, irq_en=1, then tick pulsed 3 times on consecutive cycles → pos=0x03 after the 3rd tick edge, eq=0xFF one edge later, irq=1 the edge after that; hold ack=0 → irq stays 1 and missed=0.
- From the above, pulse ack for 1 cycle → irq=0 next edge; with no tick, allmatch stays high and no new irq.
- cmp=0xFF, free-running tick for 256 cycles → pos wraps 0xFF→0x00; exactly one irq per pass; tick+cnt_clr asserted together → pos=0x00.
- cmp=0x01, irq pending without ack, then cnt_clr and tick back to 0x01 → missed=1 and irq stays 1; ack on the same cycle as a second rise → irq stays 1 and missed is cleared.
- irq_en=0 while a match rise occurs → irq stays 0; irq_en=1 later with allmatch still high → irq stays 0. irq_en dropped while PEND → irq=0 next edge.
- resetl pulsed low mid-PEND, between clock edges → irq, missed, eq and pos go to 0 immediately and cmp=0xFF; the first edge after release shows no spurious irq.
